i2c_tmp101_reader: RTL and testbench

Master-side I2C transaction sequencer for the TMP101 temperature read. It generates SCL and open-drain SDA control, and performs a two-byte read from the sensor's temperature register using the power-on pointer value of 0x00. It sits directly upstream of the 8-bit I2C shift register: it loads the address byte, pulses shift-enable, and feeds sampled SDA bits into it. It also collects the received bytes into a 16-bit temperature word.

---
 rtl/i2c_pkg.sv | 32 +++
 rtl/i2c_phase_timer.sv | 47 ++++
 rtl/i2c_tmp101_reader.sv | 242 ++++++++++++++++++++++++
 tb/tb_i2c_tmp101_reader.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the TMP101 temperature reader: sequencer state
// encoding, default slave address, R/W bit value and bit-slot counts.
// -----------------------------------------------------------------------------
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ACK_A,
    RD_MSB,
    M_ACK,
    RD_LSB,
    M_NACK,
    STOP
  } i2cState_t;

  localparam logic [6:0] DEFAULT_DEV_ADDR = 7'b1001000;
  localparam logic       READ_BIT         = 1'b1;

  // Data bits per byte, and slots per byte including the acknowledge slot.
  localparam int DATA_BITS = 8;
  localparam int SLOT_BITS = 9;

  // Address byte sent on the bus for a read from the given 7-bit address.
  function automatic logic [7:0] readAddrByte(input logic [6:0] devAddr);
    return {devAddr, READ_BIT};
  endfunction

endpackage

// File: rtl/i2c_phase_timer.sv
// -----------------------------------------------------------------------------
// i2c_phase_timer
// Divides CLOCK into quarter SCL periods. `tick` is high on the last cycle of
// each quarter; `quarter` is the 2-bit index of the current quarter within a
// bit slot.
//
// Ports:
//   CLOCK    in   system clock
//   Reset    in   asynchronous active-high reset
//   restart  in   synchronous restart: next cycle is cycle 0 of quarter 0
//   tick     out  last cycle of the current quarter
//   quarter  out  quarter index 0..3
// -----------------------------------------------------------------------------
module i2c_phase_timer #(
  parameter int QUARTER = 125
) (
  input  logic       CLOCK,
  input  logic       Reset,
  input  logic       restart,
  output logic       tick,
  output logic [1:0] quarter
);

  localparam int CW = (QUARTER > 1) ? $clog2(QUARTER) : 1;

  logic [CW-1:0] cntReg;
  logic [1:0]    quarterReg;

  assign tick    = (cntReg == CW'(QUARTER - 1));
  assign quarter = quarterReg;

  always_ff @(posedge CLOCK or posedge Reset) begin
    if (Reset) begin
      cntReg     <= '0;
      quarterReg <= '0;
    end else if (restart) begin
      cntReg     <= '0;
      quarterReg <= '0;
    end else if (tick) begin
      cntReg     <= '0;
      quarterReg <= quarterReg + 2'd1;
    end else begin
      cntReg     <= cntReg + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_tmp101_reader.sv
// -----------------------------------------------------------------------------
// i2c_tmp101_reader
// I2C master sequencer performing a two-byte read of the TMP101 temperature
// register (pointer left at its power-on value). Drives SCL and the open-drain
// SDA pull-down, controls an external 8-bit shift register for the address
// byte and the received bytes, and publishes the reading as a 16-bit word.
//
// Ports:
//   CLOCK         in   system clock
//   Reset         in   asynchronous active-high reset
//   Start         in   read request, honoured only while idle
//   SDA_in        in   synchronised SDA level
//   SDA_oe        out  1 = pull SDA low
//   SCL           out  I2C clock
//   WriteLoad     out  pulse: shift register loads SentData
//   SentData      out  address byte {DEV_ADDR, read}
//   ShiftorHold   out  pulse: shift register shifts left one place
//   ShiftIn       out  bit entering the shift register LSB
//   ShiftOut      in   shift register MSB
//   ReceivedData  in   shift register contents
//   Temp          out  last good reading {MSB, LSB}
//   Busy          out  transaction in progress
//   Done          out  pulse at end of transaction
//   AckError      out  address byte was not acknowledged
// -----------------------------------------------------------------------------
module i2c_tmp101_reader
  import i2c_pkg::*;
#(
  parameter int         QUARTER  = 125,
  parameter logic [6:0] DEV_ADDR = DEFAULT_DEV_ADDR
) (
  input  logic        CLOCK,
  input  logic        Reset,
  input  logic        Start,
  input  logic        SDA_in,
  output logic        SDA_oe,
  output logic        SCL,
  output logic        WriteLoad,
  output logic [7:0]  SentData,
  output logic        ShiftorHold,
  output logic        ShiftIn,
  input  logic        ShiftOut,
  input  logic [7:0]  ReceivedData,
  output logic [15:0] Temp,
  output logic        Busy,
  output logic        Done,
  output logic        AckError
);

  i2cState_t   stateReg, stateNext;
  logic [2:0]  bitCntReg, bitCntNext;
  logic [7:0]  msbReg, msbNext;
  logic [7:0]  lsbReg, lsbNext;
  logic [15:0] tempReg, tempNext;
  logic        busyReg, busyNext;
  logic        doneReg, doneNext;
  logic        ackErrReg, ackErrNext;
  logic        ackBitReg, ackBitNext;
  logic        writeLoadReg, writeLoadNext;

  logic        timerRestart;
  logic        tick;
  logic [1:0]  quarter;
  logic        slotEnd;
  logic        sampleEnd;
  logic        lastBit;

  i2c_phase_timer #(
    .QUARTER (QUARTER)
  ) phaseTimer (
    .CLOCK   (CLOCK),
    .Reset   (Reset),
    .restart (timerRestart),
    .tick    (tick),
    .quarter (quarter)
  );

  assign slotEnd   = tick && (quarter == 2'd3);
  assign sampleEnd = tick && (quarter == 2'd2);
  assign lastBit   = (bitCntReg == 3'(DATA_BITS - 1));

  assign SentData  = readAddrByte(DEV_ADDR);
  assign WriteLoad = writeLoadReg;
  assign Temp      = tempReg;
  assign Busy      = busyReg;
  assign Done      = doneReg;
  assign AckError  = ackErrReg;

  always_ff @(posedge CLOCK or posedge Reset) begin
    if (Reset) begin
      stateReg     <= IDLE;
      bitCntReg    <= '0;
      msbReg       <= '0;
      lsbReg       <= '0;
      tempReg      <= '0;
      busyReg      <= 1'b0;
      doneReg      <= 1'b0;
      ackErrReg    <= 1'b0;
      ackBitReg    <= 1'b0;
      writeLoadReg <= 1'b0;
    end else begin
      stateReg     <= stateNext;
      bitCntReg    <= bitCntNext;
      msbReg       <= msbNext;
      lsbReg       <= lsbNext;
      tempReg      <= tempNext;
      busyReg      <= busyNext;
      doneReg      <= doneNext;
      ackErrReg    <= ackErrNext;
      ackBitReg    <= ackBitNext;
      writeLoadReg <= writeLoadNext;
    end
  end

  // SCL and SDA_oe are decoded straight from state and quarter so that an
  // asynchronous reset releases the bus in the same cycle.
  always_comb begin
    stateNext     = stateReg;
    bitCntNext    = bitCntReg;
    msbNext       = msbReg;
    lsbNext       = lsbReg;
    tempNext      = tempReg;
    busyNext      = busyReg;
    doneNext      = 1'b0;
    ackErrNext    = ackErrReg;
    ackBitNext    = ackBitReg;
    writeLoadNext = 1'b0;
    timerRestart  = 1'b0;
    SCL           = 1'b1;
    SDA_oe        = 1'b0;
    ShiftorHold   = 1'b0;
    ShiftIn       = 1'b0;

    case (stateReg)
      IDLE: begin
        if (Start) begin
          stateNext     = START;
          writeLoadNext = 1'b1;
          busyNext      = 1'b1;
          ackErrNext    = 1'b0;
          timerRestart  = 1'b1;
          bitCntNext    = '0;
        end
      end

      START: begin
        // SDA falls at q1 with SCL still high: start condition.
        SDA_oe = (quarter != 2'd0);
        if (slotEnd) begin
          stateNext  = ADDR;
          bitCntNext = '0;
        end
      end

      ADDR: begin
        SCL         = quarter[1];
        SDA_oe      = ~ShiftOut;
        ShiftorHold = slotEnd;
        if (slotEnd) begin
          if (lastBit) begin
            stateNext  = ACK_A;
            bitCntNext = '0;
          end else begin
            bitCntNext = bitCntReg + 3'd1;
          end
        end
      end

      ACK_A: begin
        SCL = quarter[1];
        if (sampleEnd) begin
          ackBitNext = SDA_in;
        end
        if (slotEnd) begin
          if (ackBitReg) begin
            ackErrNext = 1'b1;
            stateNext  = STOP;
          end else begin
            stateNext  = RD_MSB;
          end
        end
      end

      RD_MSB, RD_LSB: begin
        SCL = quarter[1];
        if (sampleEnd) begin
          ShiftIn     = SDA_in;
          ShiftorHold = 1'b1;
        end
        if (slotEnd) begin
          if (lastBit) begin
            bitCntNext = '0;
            if (stateReg == RD_MSB) begin
              msbNext   = ReceivedData;
              stateNext = M_ACK;
            end else begin
              lsbNext   = ReceivedData;
              stateNext = M_NACK;
            end
          end else begin
            bitCntNext = bitCntReg + 3'd1;
          end
        end
      end

      M_ACK: begin
        SCL    = quarter[1];
        SDA_oe = 1'b1;
        if (slotEnd) begin
          stateNext = RD_LSB;
        end
      end

      M_NACK: begin
        SCL = quarter[1];
        if (slotEnd) begin
          stateNext = STOP;
        end
      end

      STOP: begin
        // SDA held low through the SCL rise, released at q2: stop condition.
        SCL    = (quarter != 2'd0);
        SDA_oe = ~quarter[1];
        if (slotEnd) begin
          stateNext = IDLE;
          doneNext  = 1'b1;
          busyNext  = 1'b0;
          // Both bytes are held until here so Temp never shows a torn value.
          if (!ackErrReg) begin
            tempNext = {msbReg, lsbReg};
          end
        end
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_tmp101_reader.sv
// -----------------------------------------------------------------------------
// tb_i2c_tmp101_reader
// Drives randomized TMP101 reads through i2c_tmp101_reader with a behavioural
// sensor on the bus and an 8-bit shift register model; a monitor compares
// each Done against the expected result queued by the stimulus.
// -----------------------------------------------------------------------------
module tb_i2c_tmp101_reader;

  localparam int Q = 4;

  logic        CLOCK = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic        SDA_in;
  logic        SDA_oe;
  logic        SCL;
  logic        WriteLoad;
  logic [7:0]  SentData;
  logic        ShiftorHold;
  logic        ShiftIn;
  logic        ShiftOut;
  logic [7:0]  ReceivedData;
  logic [15:0] Temp;
  logic        Busy;
  logic        Done;
  logic        AckError;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] temp;
    logic        ackErr;
    int          dur;
  } expTxn_t;

  expTxn_t expQ[$];

  // sensor configuration for the current transaction
  logic       slvAck = 1'b1;
  logic [7:0] slvB0  = 8'h00;
  logic [7:0] slvB1  = 8'h00;
  logic       slaveOe = 1'b0;

  logic [7:0]  srReg;
  logic        sdaBus;
  logic [15:0] modelTemp = 16'h0000;
  int          cyc = 0;

  // bus observer / sensor state
  logic       prevScl = 1'b1;
  logic       prevSda = 1'b1;
  logic       slvActive = 1'b0;
  int         falls = 0;
  int         rises = 0;
  int         slot;
  logic [7:0] addrSeen = 8'h00;
  logic       mAckBit = 1'b1;
  logic       mNackBit = 1'b0;
  int         rise0Cyc = 0;
  int         rise1Cyc = 0;
  int         startCnt = 0;
  int         stopCnt = 0;
  logic       busyPrev = 1'b0;
  int         busyStartCyc = 0;
  int         overlapCnt = 0;
  expTxn_t    cur;

  i2c_tmp101_reader #(
    .QUARTER (Q)
  ) dut (
    .CLOCK        (CLOCK),
    .Reset        (Reset),
    .Start        (Start),
    .SDA_in       (SDA_in),
    .SDA_oe       (SDA_oe),
    .SCL          (SCL),
    .WriteLoad    (WriteLoad),
    .SentData     (SentData),
    .ShiftorHold  (ShiftorHold),
    .ShiftIn      (ShiftIn),
    .ShiftOut     (ShiftOut),
    .ReceivedData (ReceivedData),
    .Temp         (Temp),
    .Busy         (Busy),
    .Done         (Done),
    .AckError     (AckError)
  );

  always #5 CLOCK = ~CLOCK;

  always @(posedge CLOCK) cyc <= cyc + 1;

  // External 8-bit shift register the sequencer controls.
  always @(posedge CLOCK or posedge Reset) begin
    if (Reset)            srReg <= 8'h00;
    else if (WriteLoad)   srReg <= SentData;
    else if (ShiftorHold) srReg <= {srReg[6:0], ShiftIn};
  end
  assign ShiftOut     = srReg[7];
  assign ReceivedData = srReg;

  // Open-drain wired-AND bus with a pull-up.
  assign sdaBus = ~SDA_oe & ~slaveOe;
  assign SDA_in = sdaBus;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Sensor model, bus-condition observer and scoreboard monitor.
  always @(negedge CLOCK) begin
    if (Reset) begin
      slaveOe   = 1'b0;
      slvActive = 1'b0;
      startCnt  = 0;
      stopCnt   = 0;
      busyPrev  = 1'b0;
      expQ.delete();
      prevScl   = SCL;
      prevSda   = ~SDA_oe;
    end else begin
      if (WriteLoad && ShiftorHold) overlapCnt++;

      if (SCL && prevScl && (sdaBus !== prevSda)) begin
        // SDA moved while SCL high: only a start or stop may do that.
        if (!sdaBus) begin
          startCnt++;
          slvActive = 1'b1;
          falls     = 0;
          rises     = 0;
          addrSeen  = 8'h00;
        end else begin
          stopCnt++;
          slvActive = 1'b0;
        end
      end else if (slvActive && SCL && !prevScl) begin
        slot = rises;
        rises++;
        if (slot < 8)   addrSeen = {addrSeen[6:0], sdaBus};
        if (slot == 0)  rise0Cyc = cyc;
        if (slot == 1)  rise1Cyc = cyc;
        if (slot == 17) mAckBit  = sdaBus;
        if (slot == 26) mNackBit = sdaBus;
      end else if (slvActive && !SCL && prevScl) begin
        // Slot `slot` begins: the sensor sets up its bit while SCL is low.
        slot = falls;
        falls++;
        slaveOe = 1'b0;
        if (slvAck) begin
          if (slot == 8)                    slaveOe = 1'b1;
          else if (slot >= 9 && slot <= 16)  slaveOe = ~slvB0[16 - slot];
          else if (slot >= 18 && slot <= 25) slaveOe = ~slvB1[25 - slot];
        end
      end
      prevScl = SCL;
      prevSda = ~SDA_oe & ~slaveOe;

      if (Busy && !busyPrev) busyStartCyc = cyc;
      busyPrev = Busy;

      if (Done) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got Done at cycle %0d, expected none", cyc);
        end else begin
          cur = expQ.pop_front();
          $display("txn done: Temp=%04h AckError=%0d cycles=%0d", Temp, AckError, cyc - busyStartCyc);
          check("temp", 32'(Temp), 32'(cur.temp));
          check("ack_error", 32'(AckError), 32'(cur.ackErr));
          check("busy_at_done", 32'(Busy), 32'd0);
          check("done_latency", 32'(cyc - busyStartCyc), 32'(cur.dur));
          check("addr_byte", 32'(addrSeen), 32'h91);
          check("start_cond_count", 32'(startCnt), 32'd1);
          check("stop_cond_count", 32'(stopCnt), 32'd1);
          check("scl_period", 32'(rise1Cyc - rise0Cyc), 32'(4 * Q));
          if (!cur.ackErr) begin
            check("master_ack", 32'(mAckBit), 32'd0);
            check("master_nack", 32'(mNackBit), 32'd1);
          end
        end
        startCnt = 0;
        stopCnt  = 0;
      end
    end
  end

  task automatic runTxn(input logic ack, input logic [7:0] b0, input logic [7:0] b1, input bit hammer);
    expTxn_t e;
    int n;
    slvAck = ack;
    slvB0  = b0;
    slvB1  = b1;
    if (ack) modelTemp = {b0, b1};
    e.temp   = modelTemp;
    e.ackErr = ~ack;
    e.dur    = (ack ? 116 : 44) * Q;
    expQ.push_back(e);

    @(negedge CLOCK);
    Start = 1'b1;
    @(negedge CLOCK);
    check("busy_latency", 32'(Busy), 32'd1);
    if (hammer) begin
      for (int i = 0; i < 20 * Q; i++) begin
        Start = 1'($urandom_range(0, 1));
        @(negedge CLOCK);
      end
    end
    Start = 1'b0;
    n = 0;
    while (Busy && n < 130 * Q) begin
      @(negedge CLOCK);
      n++;
    end
    if (Busy) check("done_timeout", 32'(Busy), 32'd0);
    repeat (3) @(negedge CLOCK);
    check("no_retrigger", 32'(Busy), 32'd0);
  endtask

  initial begin
    int n;
    Reset = 1'b1;
    repeat (3) @(negedge CLOCK);
    check("rst_scl", 32'(SCL), 32'd1);
    check("rst_sda_oe", 32'(SDA_oe), 32'd0);
    check("rst_writeload", 32'(WriteLoad), 32'd0);
    check("rst_shift", 32'(ShiftorHold), 32'd0);
    check("rst_shiftin", 32'(ShiftIn), 32'd0);
    check("rst_temp", 32'(Temp), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_ackerr", 32'(AckError), 32'd0);
    check("sentdata", 32'(SentData), 32'h91);
    Reset = 1'b0;
    repeat (2) @(negedge CLOCK);

    runTxn(1'b1, 8'h19, 8'h40, 1'b0);
    runTxn(1'b0, 8'hAA, 8'h55, 1'b0);
    runTxn(1'b1, 8'($urandom), 8'($urandom), 1'b1);

    // Reset in the middle of the MSB byte (bit 3 = slot 12).
    slvAck = 1'b1;
    slvB0  = 8'($urandom);
    slvB1  = 8'($urandom);
    expQ.push_back('{temp: 16'h0, ackErr: 1'b0, dur: 0});
    @(negedge CLOCK);
    Start = 1'b1;
    @(negedge CLOCK);
    Start = 1'b0;
    n = 0;
    while (falls != 13 && n < 60 * Q) begin
      @(negedge CLOCK);
      n++;
    end
    check("reach_rd_msb_bit3", 32'(falls), 32'd13);
    #2 Reset = 1'b1;
    #1;
    check("midrst_scl", 32'(SCL), 32'd1);
    check("midrst_sda_oe", 32'(SDA_oe), 32'd0);
    check("midrst_busy", 32'(Busy), 32'd0);
    check("midrst_temp", 32'(Temp), 32'd0);
    modelTemp = 16'h0000;
    repeat (3) @(negedge CLOCK);
    Reset = 1'b0;
    repeat (2) @(negedge CLOCK);

    runTxn(1'b1, 8'($urandom), 8'($urandom), 1'b0);
    runTxn(1'b1, 8'hFF, 8'hF0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      runTxn(($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), bit'($urandom_range(0, 1)));
    end

    repeat (10) @(negedge CLOCK);
    check("pending_expected", 32'(expQ.size()), 32'd0);
    check("load_shift_overlap", 32'(overlapCnt), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
